// File: rtl/tt_um_ay5876_moore_machine_pkg.sv
// Shared types and pin map for the 1011 Moore sequence detector.
// Holds the state enum, pin index constants and the next-state function.
package tt_um_ay5876_moore_machine_pkg;

    typedef enum logic [2:0] {
        S0 = 3'd0,
        S1 = 3'd1,
        S2 = 3'd2,
        S3 = 3'd3,
        S4 = 3'd4
    } state_t;

    localparam int DIN       = 0;
    localparam int EN        = 1;
    localparam int CLR       = 2;
    localparam int DETECT    = 0;
    localparam int STATE_LSB = 1;
    localparam int LASTBIT   = 4;

    // Illegal codes fall back to S0 even when en is low.
    function automatic state_t next_state(
        input state_t s,
        input logic   en,
        input logic   din
    );
        state_t n;
        n = s;
        case (s)
            S0: if (en) n = din ? S1 : S0;
            S1: if (en) n = din ? S1 : S2;
            S2: if (en) n = din ? S3 : S0;
            S3: if (en) n = din ? S4 : S2;
            S4: if (en) n = din ? S1 : S2;
            default: n = S0;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/seq1011_fsm.sv
// Moore FSM detecting overlapping 1011 on a serial stream.
// Ports: clk, rst_n, en, din in; state_code, detect (registered), hit out.
module seq1011_fsm
    import tt_um_ay5876_moore_machine_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       din,
    output logic [2:0] state_code,
    output logic       detect,
    output logic       hit
);

    state_t state;
    state_t nxt;

    always_comb begin
        nxt = next_state(state, en, din);
    end

    // detect is registered alongside state so it equals (state == S4).
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= S0;
            detect <= 1'b0;
        end else begin
            state  <= nxt;
            detect <= (nxt == S4);
        end
    end

    // Pulses on the edge that takes S3 -> S4.
    assign hit        = en & din & (state == S3);
    assign state_code = state;

endmodule

// File: rtl/tt_um_ay5876_moore_machine.sv
// Tiny Tapeout top: 1011 detector, last-bit latch and detection counter.
// ui_in: din/en/clr; uo_out: detect/state/last bit; uio_out: counter.
module tt_um_ay5876_moore_machine
    import tt_um_ay5876_moore_machine_pkg::*;
(
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe,
    input  logic       ena,
    input  logic       clk,
    input  logic       rst_n
);

    logic       din;
    logic       en;
    logic       clr;
    logic [2:0] state_code;
    logic       detect;
    logic       hit;
    logic       last_din;
    logic [7:0] cnt;
    logic       unused_pins;

    assign din = ui_in[DIN];
    assign en  = ui_in[EN];
    assign clr = ui_in[CLR];

    assign unused_pins = &{1'b0, ena, uio_in, ui_in[7:3]};

    seq1011_fsm u_fsm (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .din        (din),
        .state_code (state_code),
        .detect     (detect),
        .hit        (hit)
    );

    // clr beats a same-edge increment; reset beats both.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= 8'd0;
        end else if (clr) begin
            cnt <= 8'd0;
        end else if (hit) begin
            cnt <= cnt + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_din <= 1'b0;
        end else if (en) begin
            last_din <= din;
        end
    end

    always_comb begin
        uo_out                        = 8'h00;
        uo_out[DETECT]                = detect;
        uo_out[STATE_LSB+2:STATE_LSB] = state_code;
        uo_out[LASTBIT]               = last_din;
    end

    assign uio_out = cnt;
    assign uio_oe  = 8'hFF;

endmodule

// File: tb/tb_tt_um_ay5876_moore_machine.sv
// Scoreboard bench for the 1011 detector top.
// Stimulus pushes expected outputs; a monitor pops and compares each cycle.
module tb_tt_um_ay5876_moore_machine;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    typedef struct {
        logic [7:0] uo;
        logic [7:0] uio;
        string      nm;
    } exp_t;

    exp_t q[$];
    int   n_chk  = 0;
    int   n_pass = 0;
    bit   done   = 0;

    tt_um_ay5876_moore_machine dut (
        .ui_in   (ui_in),
        .uo_out  (uo_out),
        .uio_in  (uio_in),
        .uio_out (uio_out),
        .uio_oe  (uio_oe),
        .ena     (ena),
        .clk     (clk),
        .rst_n   (rst_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hand-tabled state code and last bit -> expected uo_out.
    function automatic logic [7:0] mk_uo(input logic [2:0] st,
                                         input logic lb);
        return {3'b000, lb, st, (st == 3'd4)};
    endfunction

    task automatic step(input logic rn, input logic clr,
                        input logic en, input logic din,
                        input logic [2:0] st, input logic lb,
                        input logic [7:0] cnt, input string nm);
        exp_t e;
        @(negedge clk);
        rst_n  = rn;
        ui_in  = {5'($urandom), clr, en, din};
        uio_in = 8'($urandom);
        @(posedge clk);
        e.uo  = mk_uo(st, lb);
        e.uio = cnt;
        e.nm  = nm;
        q.push_back(e);
    endtask

    task automatic rst_step(input string nm);
        @(negedge clk);
        rst_n  = 1'b0;
        ui_in  = 8'($urandom);
        uio_in = 8'($urandom);
        @(posedge clk);
        q.push_back('{8'h00, 8'h00, nm});
    endtask

    // Monitor: outputs are valid every cycle, sampled 1 time unit after the edge.
    initial begin
        exp_t e;
        while (!done) begin
            @(posedge clk);
            #1;
            if (q.size() != 0) begin
                e = q.pop_front();
                n_chk++;
                if (uo_out === e.uo && uio_out === e.uio
                    && uio_oe === 8'hFF) begin
                    n_pass++;
                end else begin
                    $display("FAIL %s: uo=%h uio=%h oe=%h want uo=%h uio=%h oe=ff",
                             e.nm, uo_out, uio_out, uio_oe, e.uo, e.uio);
                end
            end
        end
    end

    initial begin
        rst_n  = 1'b0;
        ena    = 1'b1;
        ui_in  = 8'h00;
        uio_in = 8'h00;

        rst_step("reset0");
        rst_step("reset1");

        step(1, 0, 1, 1, 3'd1, 1, 8'd0, "basic_b1");
        step(1, 0, 1, 0, 3'd2, 0, 8'd0, "basic_b2");
        step(1, 0, 1, 1, 3'd3, 1, 8'd0, "basic_b3");
        step(1, 0, 1, 1, 3'd4, 1, 8'd1, "basic_b4");
        step(1, 0, 1, 0, 3'd2, 0, 8'd1, "basic_after");

        rst_step("reset_ov");
        step(1, 0, 1, 1, 3'd1, 1, 8'd0, "ov_b1");
        step(1, 0, 1, 0, 3'd2, 0, 8'd0, "ov_b2");
        step(1, 0, 1, 1, 3'd3, 1, 8'd0, "ov_b3");
        step(1, 0, 1, 1, 3'd4, 1, 8'd1, "ov_b4");
        step(1, 0, 1, 0, 3'd2, 0, 8'd1, "ov_b5");
        step(1, 0, 1, 1, 3'd3, 1, 8'd1, "ov_b6");
        step(1, 0, 1, 1, 3'd4, 1, 8'd2, "ov_b7");

        rst_step("reset_stall");
        step(1, 0, 1, 1, 3'd1, 1, 8'd0, "st_b1");
        step(1, 0, 1, 0, 3'd2, 0, 8'd0, "st_b2");
        step(1, 0, 1, 1, 3'd3, 1, 8'd0, "st_b3");
        step(1, 0, 0, 0, 3'd3, 1, 8'd0, "st_hold1");
        step(1, 0, 0, 1, 3'd3, 1, 8'd0, "st_hold2");
        step(1, 0, 0, 0, 3'd3, 1, 8'd0, "st_hold3");
        step(1, 0, 1, 1, 3'd4, 1, 8'd1, "st_b4");
        step(1, 0, 0, 0, 3'd4, 1, 8'd1, "st_s4hold1");
        step(1, 0, 0, 1, 3'd4, 1, 8'd1, "st_s4hold2");
        step(1, 0, 0, 0, 3'd4, 1, 8'd1, "st_s4hold3");

        rst_step("reset_clr");
        step(1, 0, 1, 1, 3'd1, 1, 8'd0, "clr_b1");
        step(1, 0, 1, 0, 3'd2, 0, 8'd0, "clr_b2");
        step(1, 0, 1, 1, 3'd3, 1, 8'd0, "clr_b3");
        step(1, 0, 1, 1, 3'd4, 1, 8'd1, "clr_b4");
        step(1, 0, 1, 0, 3'd2, 0, 8'd1, "clr_to_s2");
        step(1, 1, 0, 1, 3'd2, 0, 8'd0, "clr_in_s2");
        step(1, 0, 1, 1, 3'd3, 1, 8'd0, "clr_s3");
        step(1, 1, 1, 1, 3'd4, 1, 8'd0, "clr_vs_inc");

        rst_step("reset_wrap");
        for (int i = 0; i < 256; i++) begin
            step(1, 0, 1, 1, 3'd1, 1, 8'(i), "wrap_b1");
            step(1, 0, 1, 0, 3'd2, 0, 8'(i), "wrap_b2");
            step(1, 0, 1, 1, 3'd3, 1, 8'(i), "wrap_b3");
            step(1, 0, 1, 1, 3'd4, 1, 8'(i + 1), "wrap_b4");
        end

        step(1, 0, 1, 1, 3'd1, 1, 8'd0, "mid_b1");
        step(1, 0, 1, 0, 3'd2, 0, 8'd0, "mid_b2");
        step(1, 0, 1, 1, 3'd3, 1, 8'd0, "mid_b3");
        step(0, 0, 1, 1, 3'd0, 0, 8'd0, "mid_reset");
        step(1, 0, 1, 0, 3'd0, 0, 8'd0, "mid_after0");
        step(1, 0, 1, 1, 3'd1, 1, 8'd0, "mid_after1");
        step(1, 0, 1, 1, 3'd1, 1, 8'd0, "mid_after2");

        repeat (3) @(posedge clk);
        #2;
        if (q.size() != 0) begin
            n_chk++;
            $display("FAIL drain: %0d pending, want 0", q.size());
        end
        done = 1;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
